inst_pair_responder: RTL



---
 rtl/inst_pair_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inst_pair_responder.sv
// Dual-word instruction fetch responder with a one-entry pair buffer.
// Ports: clk/rst, sram_inst_* fetch side, mem_* single-word backing side.
module inst_pair_responder #(
   parameter int LINE_BYTES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sram_inst_ena,
   input  logic [31:0] sram_inst_addr,
   output logic [31:0] sram_inst_rdata_1,
   output logic [31:0] sram_inst_rdata_2,
   output logic        sram_inst_ok_1,
   output logic        sram_inst_ok_2,
   output logic        i_cache_stall_req,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int OFF = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      FETCH0,
      FETCH1
   } state_e;

   state_e      state_q, state_d;
   logic [29:0] req_addr_q, req_addr_d;
   logic        pair_q, pair_d;
   logic [31:0] w0_q, w0_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [29:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_w0_q, buf_w0_d;
   logic [31:0] buf_w1_q, buf_w1_d;
   logic        buf_ok2_q, buf_ok2_d;
   logic        buf_valid_q, buf_valid_d;

   logic hit;
   logic line_end;
   logic addr_unused;

   assign addr_unused = ^sram_inst_addr[1:0];
   assign hit = buf_valid_q && (sram_inst_addr[31:2] == buf_addr_q);
   // last word of the line: no second word, it would cross the line
   assign line_end = &sram_inst_addr[OFF-1:2];

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

   always_comb begin
      sram_inst_rdata_1 = '0;
      sram_inst_rdata_2 = '0;
      sram_inst_ok_1    = 1'b0;
      sram_inst_ok_2    = 1'b0;
      i_cache_stall_req = 1'b0;
      if (sram_inst_ena) begin
         if (hit) begin
            sram_inst_ok_1    = 1'b1;
            sram_inst_rdata_1 = buf_w0_q;
            sram_inst_ok_2    = buf_ok2_q;
            sram_inst_rdata_2 = buf_ok2_q ? buf_w1_q : '0;
         end else begin
            i_cache_stall_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      pair_d      = pair_q;
      w0_d        = w0_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      buf_addr_d  = buf_addr_q;
      buf_w0_d    = buf_w0_q;
      buf_w1_d    = buf_w1_q;
      buf_ok2_d   = buf_ok2_q;
      buf_valid_d = buf_valid_q;
      unique case (state_q)
         IDLE: begin
            if (sram_inst_ena && !hit) begin
               req_addr_d = sram_inst_addr[31:2];
               pair_d     = !line_end;
               mem_req_d  = 1'b1;
               mem_addr_d = {sram_inst_addr[31:2], 2'b00};
               state_d    = FETCH0;
            end
         end
         FETCH0: begin
            if (mem_ack) begin
               w0_d = mem_rdata;
               if (pair_q) begin
                  mem_addr_d = mem_addr_q + 32'd4;
                  state_d    = FETCH1;
               end else begin
                  buf_addr_d  = req_addr_q;
                  buf_w0_d    = mem_rdata;
                  buf_ok2_d   = 1'b0;
                  buf_valid_d = 1'b1;
                  mem_req_d   = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         FETCH1: begin
            if (mem_ack) begin
               buf_addr_d  = req_addr_q;
               buf_w0_d    = w0_q;
               buf_w1_d    = mem_rdata;
               buf_ok2_d   = 1'b1;
               buf_valid_d = 1'b1;
               mem_req_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_addr_q  <= '0;
         pair_q      <= 1'b0;
         w0_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         buf_addr_q  <= '0;
         buf_w0_q    <= '0;
         buf_w1_q    <= '0;
         buf_ok2_q   <= 1'b0;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         pair_q      <= pair_d;
         w0_q        <= w0_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         buf_addr_q  <= buf_addr_d;
         buf_w0_q    <= buf_w0_d;
         buf_w1_q    <= buf_w1_d;
         buf_ok2_q   <= buf_ok2_d;
         buf_valid_q <= buf_valid_d;
      end
   end

endmodule
